// File: rtl/cellrv32_package.sv
// Shared definitions for the vector store sequencer.
package cellrv32_package;

    // Store sequencer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } vstore_state_e;

endpackage

// File: rtl/vstore_sequencer.sv
// Vector store sequencer: reads one vector register (plus the v0 mask) in a
// single FETCH cycle, then streams the active elements to memory as strided
// write beats, one element per cycle at most.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high. A beat presented with mem_valid_o=1 keeps its valid, address
// and data unchanged until mem_ready_i accepts it; requests are only taken
// while req_ready_o=1 (IDLE).
module vstore_sequencer
    import cellrv32_package::*;
#(
    parameter int VREGS      = 32,
    parameter int ELEMENTS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                           clk_i,
    input  logic                           reset,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [$clog2(VREGS)-1:0]       req_vs_i,
    input  logic [ADDR_WIDTH-1:0]          req_base_i,
    input  logic [ADDR_WIDTH-1:0]          req_stride_i,
    input  logic [$clog2(ELEMENTS):0]      req_vl_i,
    input  logic                           req_masked_i,
    output logic [$clog2(VREGS)-1:0]       vrf_rd_addr_o,
    input  logic [ELEMENTS*DATA_WIDTH-1:0] vrf_data_i,
    output logic [$clog2(VREGS)-1:0]       vrf_mask_src_o,
    input  logic [ELEMENTS-1:0]            vrf_mask_i,
    output logic                           mem_valid_o,
    input  logic                           mem_ready_i,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    output logic [DATA_WIDTH-1:0]          mem_data_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int VS_W  = $clog2(VREGS);
    localparam int VL_W  = $clog2(ELEMENTS) + 1;
    localparam int IDX_W = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;

    vstore_state_e               state_q;
    logic [VS_W-1:0]             vs_q;
    logic [ADDR_WIDTH-1:0]       base_q;
    logic [ADDR_WIDTH-1:0]       stride_q;
    logic [VL_W-1:0]             vl_q;
    logic                        masked_q;
    logic [ELEMENTS*DATA_WIDTH-1:0] data_q;
    logic [ELEMENTS-1:0]         mask_q;
    logic [IDX_W-1:0]            idx_q;
    logic [ADDR_WIDTH-1:0]       acc_q;

    logic [VL_W-1:0]             idx_ext;
    logic [VL_W-1:0]             vl_clamped;
    logic                        cur_active;
    logic                        cur_last;
    logic                        fetch_any;

    // Element-activity decode for the element currently addressed in SEND.
    always_comb begin
        idx_ext    = VL_W'(idx_q);
        cur_active = (state_q == SEND) && (idx_ext < vl_q) && (!masked_q || mask_q[idx_q]);
        cur_last   = (idx_ext == (vl_q - VL_W'(1)));
        vl_clamped = (req_vl_i > VL_W'(ELEMENTS)) ? VL_W'(ELEMENTS) : req_vl_i;
    end

    // Looks at the mask being captured this FETCH cycle to decide whether any
    // element will produce a beat; if none does, SEND is skipped entirely.
    always_comb begin
        fetch_any = 1'b0;
        for (int k = 0; k < ELEMENTS; k++) begin
            if ((VL_W'(k) < vl_q) && (!masked_q || vrf_mask_i[k])) begin
                fetch_any = 1'b1;
            end
        end
    end

    // Control FSM plus request latches, VRF snapshot and address walker.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q  <= IDLE;
            vs_q     <= '0;
            base_q   <= '0;
            stride_q <= '0;
            vl_q     <= '0;
            masked_q <= 1'b0;
            data_q   <= '0;
            mask_q   <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        vs_q     <= req_vs_i;
                        base_q   <= req_base_i;
                        stride_q <= req_stride_i;
                        vl_q     <= vl_clamped;
                        masked_q <= req_masked_i;
                        state_q  <= FETCH;
                    end
                end
                FETCH: begin
                    // Snapshot isolates the beats from later VRF writes.
                    data_q  <= vrf_data_i;
                    mask_q  <= vrf_mask_i;
                    idx_q   <= '0;
                    acc_q   <= base_q;
                    state_q <= fetch_any ? SEND : DONE;
                end
                SEND: begin
                    // Inactive elements are skipped in one cycle with no beat.
                    if (!cur_active || mem_ready_i) begin
                        idx_q <= idx_q + IDX_W'(1);
                        acc_q <= acc_q + stride_q;
                        if (cur_last) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from registered state only.
    always_comb begin
        req_ready_o    = (state_q == IDLE);
        busy_o         = (state_q != IDLE);
        done_o         = (state_q == DONE);
        mem_valid_o    = cur_active;
        mem_addr_o     = acc_q;
        mem_data_o     = data_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
        vrf_rd_addr_o  = vs_q;
        vrf_mask_src_o = '0;
    end

endmodule

// File: tb/tb_vstore_sequencer.sv
// Bench for vstore_sequencer: directed scenarios followed by randomized
// requests, with beats compared against an expected queue built from the
// element/mask/stride rules.
module tb_vstore_sequencer;

    localparam int VREGS    = 32;
    localparam int ELEMENTS = 4;
    localparam int DW       = 32;
    localparam int AW       = 32;

    // Clock and reset
    logic clk_i = 1'b0;
    logic reset;
    always #5 clk_i = ~clk_i;

    logic                     req_valid_i;
    logic                     req_ready_o;
    logic [4:0]               req_vs_i;
    logic [AW-1:0]            req_base_i;
    logic [AW-1:0]            req_stride_i;
    logic [2:0]               req_vl_i;
    logic                     req_masked_i;
    logic [4:0]               vrf_rd_addr_o;
    logic [ELEMENTS*DW-1:0]   vrf_data_i;
    logic [4:0]               vrf_mask_src_o;
    logic [ELEMENTS-1:0]      vrf_mask_i;
    logic                     mem_valid_o;
    logic                     mem_ready_i;
    logic [AW-1:0]            mem_addr_o;
    logic [DW-1:0]            mem_data_o;
    logic                     busy_o;
    logic                     done_o;

    vstore_sequencer #(
        .VREGS(VREGS), .ELEMENTS(ELEMENTS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
    ) dut (
        .clk_i(clk_i), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_vs_i(req_vs_i), .req_base_i(req_base_i), .req_stride_i(req_stride_i),
        .req_vl_i(req_vl_i), .req_masked_i(req_masked_i),
        .vrf_rd_addr_o(vrf_rd_addr_o), .vrf_data_i(vrf_data_i),
        .vrf_mask_src_o(vrf_mask_src_o), .vrf_mask_i(vrf_mask_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    // Behavioural register file and v0 mask
    logic [DW-1:0]       vrf [VREGS][ELEMENTS];
    logic [ELEMENTS-1:0] v0_mask;

    always_comb begin
        vrf_data_i = '0;
        for (int k = 0; k < ELEMENTS; k++) vrf_data_i[k*DW +: DW] = vrf[vrf_rd_addr_o][k];
    end
    assign vrf_mask_i = v0_mask;

    // Scoreboard state
    logic [63:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_beats  = 0;
    int n_valid_cycles = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Beat monitor: compares accepted beats with the expected queue and
    // checks that a stalled beat stays unchanged.
    always @(negedge clk_i) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (mem_valid_o) begin
                n_valid_cycles++;
                if (prev_stall) begin
                    check("hold_addr", mem_addr_o, prev_addr);
                    check("hold_data", mem_data_o, prev_data);
                end
                if (mem_ready_i) begin
                    n_beats++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        logic [63:0] e;
                        e = exp_q.pop_front();
                        check("beat_addr", mem_addr_o, e[63:32]);
                        check("beat_data", mem_data_o, e[31:0]);
                    end
                end
            end else if (prev_stall) begin
                check("hold_valid", 0, 1);
            end
            prev_stall = mem_valid_o && !mem_ready_i;
            prev_addr  = mem_addr_o;
            prev_data  = mem_data_o;
        end
    end

    // Reference model: list of (address, data) beats a request must produce.
    task automatic build_expected(input logic [4:0] vs, input logic [31:0] base,
                                  input logic [31:0] stride, input logic [2:0] vl,
                                  input logic masked, output int n_act, output int vl_eff);
        logic [31:0] a;
        vl_eff = (int'(vl) > ELEMENTS) ? ELEMENTS : int'(vl);
        n_act  = 0;
        for (int k = 0; k < vl_eff; k++) begin
            if (!masked || v0_mask[k]) begin
                a = base + stride * 32'(k);
                exp_q.push_back({a, vrf[vs][k]});
                n_act++;
            end
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            1:       return logic'($urandom_range(0, 1));
            2:       return !(cyc >= 2 && cyc <= 4);
            default: return 1'b1;
        endcase
    endfunction

    // Driver: one request from IDLE through done, then back to IDLE.
    // exp_done < 0 skips the completion-cycle check.
    task automatic do_req(input logic [4:0] vs, input logic [31:0] base, input logic [31:0] stride,
                          input logic [2:0] vl, input logic masked, input int ready_mode,
                          input bit noise, input int exp_done, input int exp_valid_cycles);
        int n_act, vl_eff, done_cyc, beats0, vcyc0;
        build_expected(vs, base, stride, vl, masked, n_act, vl_eff);
        beats0 = n_beats;
        vcyc0  = n_valid_cycles;
        check("ready_idle", req_ready_o, 1);
        req_valid_i  = 1'b1;
        req_vs_i     = vs;
        req_base_i   = base;
        req_stride_i = stride;
        req_vl_i     = vl;
        req_masked_i = masked;
        mem_ready_i  = ready_for(ready_mode, 0);
        @(posedge clk_i);
        done_cyc = -1;
        for (int cyc = 1; cyc < 100; cyc++) begin
            #1;
            mem_ready_i = ready_for(ready_mode, cyc);
            if (noise && cyc <= 2) begin
                req_valid_i  = 1'b1;
                req_vs_i     = 5'($urandom);
                req_base_i   = $urandom;
                req_stride_i = $urandom;
                req_vl_i     = 3'($urandom);
                req_masked_i = 1'($urandom);
            end else begin
                req_valid_i = 1'b0;
            end
            @(negedge clk_i);
            if (cyc == 1) begin
                check("fetch_rd_addr", vrf_rd_addr_o, vs);
                check("fetch_busy", busy_o, 1);
            end
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk_i);
        end
        check("done_seen", done_cyc >= 0, 1);
        if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
        if (exp_valid_cycles >= 0) check("valid_cycles", n_valid_cycles - vcyc0, exp_valid_cycles);
        check("beat_count", n_beats - beats0, n_act);
        check("exp_q_empty", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        check("done_one_cycle", done_o, 0);
        check("idle_busy", busy_o, 0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int n_act, vl_eff, beats0, done_seen;
        logic [31:0] stride;

        reset        = 1'b1;
        req_valid_i  = 1'b0;
        req_vs_i     = '0;
        req_base_i   = '0;
        req_stride_i = '0;
        req_vl_i     = '0;
        req_masked_i = 1'b0;
        mem_ready_i  = 1'b1;
        v0_mask      = '0;
        for (int r = 0; r < VREGS; r++)
            for (int k = 0; k < ELEMENTS; k++) vrf[r][k] = $urandom;

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready", req_ready_o, 1);
        check("rst_valid", mem_valid_o, 0);
        check("rst_done", done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_data", mem_data_o, 0);
        check("rst_rd_addr", vrf_rd_addr_o, 0);
        check("mask_src", vrf_mask_src_o, 0);
        @(posedge clk_i);
        #1;
        reset = 1'b0;
        @(posedge clk_i);
        #1;

        // S1: four contiguous beats, done in cycle 6
        vrf[3][0] = 32'hA; vrf[3][1] = 32'hB; vrf[3][2] = 32'hC; vrf[3][3] = 32'hD;
        do_req(5'd3, 32'h1000, 32'd4, 3'd4, 1'b0, 0, 1'b0, 6, 4);

        // S2: masked 0101, skipped elements still cost one cycle each
        v0_mask = 4'b0101;
        do_req(5'd3, 32'h1000, 32'd4, 3'd4, 1'b1, 0, 1'b0, 6, 2);

        // S3: first beat stalled three cycles, vl=2
        do_req(5'd3, 32'h1000, 32'd4, 3'd2, 1'b0, 2, 1'b0, 7, 5);

        // S4: vl=0, then masked with an all-zero mask
        do_req(5'd3, 32'h1000, 32'd4, 3'd0, 1'b0, 0, 1'b0, 2, 0);
        v0_mask = 4'b0000;
        do_req(5'd3, 32'h1000, 32'd4, 3'd4, 1'b1, 0, 1'b0, 2, 0);

        // S5: address wrap
        do_req(5'd3, 32'hFFFF_FFFC, 32'd8, 3'd3, 1'b0, 0, 1'b0, 5, 3);

        // vl above ELEMENTS clamps; stride 0 repeats the address; busy requests ignored
        do_req(5'd7, 32'h2000, 32'd16, 3'd7, 1'b0, 0, 1'b1, 6, 4);
        do_req(5'd9, 32'h3000, 32'd0, 3'd3, 1'b0, 0, 1'b1, 5, 3);

        // S6: VRF write after FETCH is not seen; reset during the second beat
        for (int k = 0; k < ELEMENTS; k++) vrf[3][k] = 32'h100 + 32'(k);
        build_expected(5'd3, 32'h1000, 32'd4, 3'd4, 1'b0, n_act, vl_eff);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        beats0 = n_beats;
        req_valid_i = 1'b1; req_vs_i = 5'd3; req_base_i = 32'h1000;
        req_stride_i = 32'd4; req_vl_i = 3'd4; req_masked_i = 1'b0;
        mem_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        for (int k = 0; k < ELEMENTS; k++) vrf[3][k] = 32'hDEAD_0000 + 32'(k);
        @(negedge clk_i);
        check("s6_beat0_valid", mem_valid_o, 1);
        @(posedge clk_i);
        #1;
        mem_ready_i = 1'b0;
        reset = 1'b1;
        @(negedge clk_i);
        check("s6_beat1_valid", mem_valid_o, 1);
        check("s6_beat1_addr", mem_addr_o, 32'h1004);
        check("s6_beat1_data", mem_data_o, 32'h101);
        @(posedge clk_i);
        #1;
        reset = 1'b0;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        check("s6_valid_after_rst", mem_valid_o, 0);
        check("s6_ready_after_rst", req_ready_o, 1);
        check("s6_busy_after_rst", busy_o, 0);
        check("s6_addr_after_rst", mem_addr_o, 0);
        check("s6_data_after_rst", mem_data_o, 0);
        check("s6_rd_after_rst", vrf_rd_addr_o, 0);
        done_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (done_o || mem_valid_o) done_seen++;
        end
        check("s6_no_done_no_beat", done_seen, 0);
        check("s6_beat_count", n_beats - beats0, 1);
        check("s6_exp_q_empty", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk_i);
        #1;

        // Randomized requests
        for (int i = 0; i < 30; i++) begin
            logic [4:0]  vs;
            logic [31:0] base;
            logic [2:0]  vl;
            logic        masked;
            int          mode, exp_done, act, vle;
            for (int r = 0; r < VREGS; r++)
                for (int k = 0; k < ELEMENTS; k++) vrf[r][k] = $urandom;
            v0_mask = 4'($urandom);
            vs      = 5'($urandom);
            base    = $urandom;
            case ($urandom_range(0, 3))
                0:       stride = 32'd0;
                1:       stride = 32'd4;
                2:       stride = 32'hFFFF_FFFC;
                default: stride = $urandom;
            endcase
            vl     = 3'($urandom_range(0, 7));
            masked = 1'($urandom);
            mode   = i % 2;
            // Count actives from the rules to predict completion when ready stays high
            vle = (int'(vl) > ELEMENTS) ? ELEMENTS : int'(vl);
            act = 0;
            for (int k = 0; k < vle; k++) if (!masked || v0_mask[k]) act++;
            exp_done = (mode != 0) ? -1 : ((act == 0) ? 2 : 2 + vle);
            do_req(vs, base, stride, vl, masked, mode, (i % 3) == 0, exp_done, (mode != 0) ? -1 : act);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
